multiply_sequencer: RTL

Handshake front-end for the shift-and-add `Multiplier` block. It accepts operand pairs over a valid/ready interface and buffers them in a small FIFO. It issues each pair to the multiplier with a single-cycle start pulse, waits for the multiplier's finished flag, then captures the product and presents it downstream over a second valid/ready interface. Results leave in the same order as operands arrived, and only one multiplication is in flight at a time.

---
 rtl/multiply_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multiply_sequencer.sv
// rtl/multiply_sequencer.sv - valid/ready front-end that sequences operand pairs through a shift-and-add multiplier
//
// Purpose:
//   Buffers operand pairs in a DEPTH-entry FIFO and issues them one at a time to
//   an external multiplier with a one-cycle start pulse. It waits for the
//   finished flag, then holds the full-width product downstream until accepted.
//   Results leave in arrival order.
//
// Ports:
//   i_clock, i_reset                       single clock, synchronous active-high reset
//   i_valid, o_ready,
//   i_multiplicand, i_multiplier           upstream operand handshake
//   o_start, o_multiplicand, o_multiplier  issue to the multiplier
//   i_finished, i_product                  completion from the multiplier
//   o_valid, i_ready, o_product            downstream result handshake
//   o_busy                                 FSM not IDLE or FIFO non-empty
//
// Optional feature:
//   MULTIPLY_SEQUENCER_ZERO_SKIP_EN - when defined, a head pair with a zero
//   operand bypasses the multiplier. The pair goes straight to HOLD with a zero
//   product.

module multiply_sequencer #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [BITS-1:0]   i_multiplicand,
  input  logic [BITS-1:0]   i_multiplier,
  output logic              o_start,
  output logic [BITS-1:0]   o_multiplicand,
  output logic [BITS-1:0]   o_multiplier,
  input  logic              i_finished,
  input  logic [2*BITS-1:0] i_product,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [2*BITS-1:0] o_product,
  output logic              o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t state, state_next;

  logic [2*BITS-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              fifo_empty;
  logic              push, pop;
  logic [BITS-1:0]   head_a, head_b;
  logic              head_zero;
  logic              latch_ops, capture, skip;

  assign fifo_empty = (count == '0);
  // Ready depends only on the registered count, never on this cycle's pop.
  assign o_ready    = (count != FULL);
  assign push       = i_valid & o_ready;
  assign {head_a, head_b} = fifo_mem[rd_ptr];
  assign o_busy     = (state != IDLE) | ~fifo_empty;

`ifdef MULTIPLY_SEQUENCER_ZERO_SKIP_EN
  assign head_zero = (head_a == '0) | (head_b == '0);
`else
  assign head_zero = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = head_zero ? HOLD : ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (i_finished) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    o_start   = 1'b0;
    o_valid   = 1'b0;
    pop       = 1'b0;
    latch_ops = 1'b0;
    capture   = 1'b0;
    skip      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_zero) begin
            pop  = 1'b1;
            skip = 1'b1;
          end else begin
            latch_ops = 1'b1;
          end
        end
      end
      ISSUE: begin
        o_start = 1'b1;
        pop     = 1'b1;
      end
      WAIT: capture = i_finished;
      HOLD: o_valid = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {i_multiplicand, i_multiplier};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Operand and product registers. The operand outputs keep their last issued value.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_multiplicand <= '0;
      o_multiplier   <= '0;
      o_product      <= '0;
    end else begin
      if (latch_ops) begin
        o_multiplicand <= head_a;
        o_multiplier   <= head_b;
      end
      if (capture) begin
        o_product <= i_product;
      end else if (skip) begin
        o_product <= '0;
      end
    end
  end

endmodule
